muldiv_ctrl: RTL and testbench

Iterative unsigned multiply/divide controller for the MIPS core. It implements MULTU and DIVU by borrowing the shared 32-bit ALU for 32 cycles of add or subtract steps, and leaves results in internal HI/LO registers. While the controller owns the ALU, the datapath stalls. `alu_own` drives the datapath's ALU operand/oper mux, so the controller also arbitrates the ALU between the core and itself.

---
 rtl/muldiv_ctrl_pkg.sv | 20 ++
 rtl/muldiv_ctrl.sv | 124 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the iterative multiply/divide controller:
// FSM states, MULTU/DIVU op select, and the ALU operation codes it borrows.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [3:0] EXE_ALU_ADD = 4'h0;
  localparam logic [3:0] EXE_ALU_SUB = 4'h1;

  localparam logic [4:0] LAST_STEP = 5'd31;

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative unsigned MULTU/DIVU controller. Borrows the shared datapath ALU
// for 32 add (shift-add multiply) or subtract (restoring divide) steps and
// leaves the result in HI/LO.
//
// state | meaning
// IDLE  | waiting for start; ALU belongs to the core
// MUL   | shift-add multiply step each cycle, ALU owned
// DIV   | restoring divide step each cycle, ALU owned
// DONE  | one-cycle done pulse, HI/LO final
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        alu_own_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_oper_o,
  input  logic [31:0] alu_result_i
);

  state_e      state_q;
  logic [31:0] hi_q, lo_q, m_q;
  logic [4:0]  cnt_q;
  logic        busy_q, done_q;

  logic [31:0] shift_rem;
  logic        div_ge;
  logic        mul_carry;

  assign shift_rem = {hi_q[30:0], lo_q[31]};
  // A set top bit means the shifted remainder exceeds 32 bits, so it is
  // certainly >= m and the wrapped subtraction is still exact.
  assign div_ge    = hi_q[31] | (shift_rem >= m_q);
  assign mul_carry = (alu_result_i < hi_q);

  assign busy_o    = busy_q;
  assign alu_own_o = busy_q;
  assign done_o    = done_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

  // ALU operand/operation drive, decoded from state and registers only.
  always_comb begin
    alu_a_o    = 32'd0;
    alu_b_o    = 32'd0;
    alu_oper_o = EXE_ALU_ADD;
    case (state_q)
      ST_MUL: begin
        alu_a_o = hi_q;
        alu_b_o = lo_q[0] ? m_q : 32'd0;
      end
      ST_DIV: begin
        alu_a_o    = shift_rem;
        alu_b_o    = m_q;
        alu_oper_o = EXE_ALU_SUB;
      end
      default: ;
    endcase
  end

  // Sequencer: state, HI/LO/m/cnt datapath registers and registered flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      m_q     <= 32'd0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            m_q   <= src_b_i;
            cnt_q <= 5'd0;
            if (op_i == OP_DIVU && src_b_i == 32'd0) begin
              // Divide by zero skips the iteration entirely.
              hi_q    <= src_a_i;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              hi_q    <= 32'd0;
              lo_q    <= src_a_i;
              state_q <= (op_i == OP_MULTU) ? ST_MUL : ST_DIV;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (state_q == ST_MUL) begin
            hi_q <= {mul_carry, alu_result_i[31:1]};
            lo_q <= {alu_result_i[0], lo_q[31:1]};
          end else begin
            hi_q <= div_ge ? alu_result_i : shift_rem;
            lo_q <= {lo_q[30:0], div_ge};
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random MULTU/DIVU
// operations compared against plain 64-bit arithmetic.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] src_a, src_b;
  logic        busy, done, alu_own;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [3:0]  alu_oper;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in for the datapath ALU.
  always_comb begin
    alu_result = 32'd0;
    if (alu_oper == EXE_ALU_ADD) alu_result = alu_a + alu_b;
    else if (alu_oper == EXE_ALU_SUB) alu_result = alu_a - alu_b;
  end

  muldiv_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .src_a_i(src_a), .src_b_i(src_b),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo),
    .alu_own_o(alu_own), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_oper_o(alu_oper), .alu_result_i(alu_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result as {hi, lo}.
  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (o == OP_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Launch one op, follow it to done, and check timing, ALU drive and result.
  // inject_at > 0 pulses a MULTU 2x3 start during that busy cycle.
  task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input int inject_at);
    int          cyc, busy_cnt, bad_drive, done_cyc, extra_done;
    logic [63:0] exp;
    bit          div0;
    exp  = ref_result(o, a, b);
    div0 = (o == OP_DIVU) && (b == 32'd0);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; busy_cnt = 0; bad_drive = 0; done_cyc = -1;
    while (cyc <= 40) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy) busy_cnt++;
      if (alu_own !== busy) bad_drive++;
      if (busy && alu_oper !== ((o == OP_MULTU) ? EXE_ALU_ADD : EXE_ALU_SUB)) bad_drive++;
      if (inject_at > 0 && cyc == inject_at) begin
        start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, 64'(done_cyc), div0 ? 64'd1 : 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), div0 ? 64'd0 : 64'd32);
    chk({tag, " alu_drive"}, 64'(bad_drive), 64'd0);
    chk({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, " result"}, {hi, lo}, exp);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    chk({tag, " single_done"}, 64'(extra_done), 64'd0);
    chk({tag, " hold"}, {hi, lo}, exp);
    chk({tag, " idle_alu"}, {alu_a, alu_b, 28'd0, alu_oper}, {64'd0, 28'd0, EXE_ALU_ADD});
  endtask

  initial begin
    logic        ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {61'd0, busy, done, alu_own}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;

    run_op("mul_ones", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("mul_ones_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mul_small", OP_MULTU, 32'h0001_2345, 32'h0001_0000, 0);
    chk("mul_small_const", {hi, lo}, 64'h0000_0001_2345_0000);
    run_op("div_100_7", OP_DIVU, 32'd100, 32'd7, 0);
    chk("div_100_7_const", {hi, lo}, {32'd2, 32'd14});
    run_op("div_top", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    chk("div_top_const", {hi, lo}, {32'h7FFF_FFFE, 32'd1});
    run_op("div_zero", OP_DIVU, 32'h1234, 32'd0, 0);
    chk("div_zero_const", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op("start_busy", OP_DIVU, 32'd100, 32'd7, 5);

    // Reset during step 10 of a multiply.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5677;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_flags", {61'd0, busy, done, alu_own}, 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    run_op("mul_6_7", OP_MULTU, 32'd6, 32'd7, 0);
    chk("mul_6_7_lo", {32'd0, lo}, 64'd42);

    for (int t = 0; t < 24; t++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 15);
        1:       rb = $urandom & 32'h0000_FFFF;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", t), ro, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
